// File: rtl/bnn_pkg.sv
// bnn_pkg: shared BNN accelerator constants and the argmax scan state type.
package bnn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W = 16;
  localparam int CLS_W = 4;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;
endpackage

// File: rtl/fc_argmax.sv
// fc_argmax: latches the FC score vector and scans it sequentially for the
// highest signed score, reporting the winning class with a one-cycle done.
module fc_argmax
  import bnn_pkg::*;
#(
  parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
  parameter int SCORE_W = bnn_pkg::SCORE_W,
  parameter int CLS_W = bnn_pkg::CLS_W
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           fc_ovalid,
  input  logic [NUM_CLASSES*SCORE_W-1:0] fc_scores,
  output logic                           in_ready,
  output logic                           done,
  output logic [CLS_W-1:0]               classes_b,
  output logic [SCORE_W-1:0]             max_score
);
  argmax_state_t state, state_d;
  logic signed [SCORE_W-1:0] bank [NUM_CLASSES];
  logic signed [SCORE_W-1:0] best_score, cur, nxt_score;
  logic [CLS_W-1:0] best_idx, ptr, nxt_idx;
  logic accept, last, gt;
  always_comb begin
    in_ready = state == IDLE;
    done = state == DONE;
    accept = in_ready && fc_ovalid;
    last = ptr == CLS_W'(NUM_CLASSES - 1);
    cur = bank[ptr];
    gt = cur > best_score;
    nxt_score = gt ? cur : best_score;
    nxt_idx = gt ? ptr : best_idx;
    state_d = (state == IDLE) ? (fc_ovalid ? SCAN : IDLE) :
              (state == SCAN) ? (last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr <= '0;
      best_score <= '0;
      best_idx <= '0;
      classes_b <= '0;
      max_score <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) bank[k] <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        for (int k = 0; k < NUM_CLASSES; k++) bank[k] <= fc_scores[k*SCORE_W +: SCORE_W];
        best_score <= fc_scores[SCORE_W-1:0];
        best_idx <= '0;
        ptr <= CLS_W'(1);
      end else if (state == SCAN) begin
        best_score <= nxt_score;
        best_idx <= nxt_idx;
        // the final compare folds straight into the outputs on the edge entering DONE
        if (last) begin
          classes_b <= nxt_idx;
          max_score <= nxt_score;
        end else ptr <= ptr + CLS_W'(1);
      end
    end
  end
endmodule
